// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor slice walks the operands LSB first and
// computes D = A - B - Bin with borrow-out Bout, taking WIDTH clocks per operation.
//
// state   | meaning
// S_IDLE  | waiting for start; operands sampled on the accepting edge
// S_SHIFT | one operand bit consumed per edge, busy high
// S_DONE  | result published, done high for one cycle
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_bnext;
    logic [WIDTH-1:0] w_res_next;

    assign w_d     = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_bnext = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);

    // The new bit enters at the MSB so that after WIDTH shifts the LSB has reached bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_borrow <= bus.Bin;
                        r_res    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= w_res_next;
                    r_borrow <= w_bnext;
                    r_cnt    <= r_cnt + 1'b1;
                    // D/Bout only change here, so they never expose a partial result.
                    if (r_cnt == LAST) begin
                        r_d     <= w_res_next;
                        r_bout  <= w_bnext;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.D    = r_d;
    assign bus.Bout = r_bout;
endmodule
